decode_stage: RTL and testbench

- RV32I instruction-decode pipeline stage; sits directly upstream of register_file.
- Takes fetched instruction/PC, drives register_file read addresses, captures operands, decodes fields/immediate into an ID/EX output register.
- Provides writeback bypass (register_file writes on posedge, so same-cycle read returns old value), load-use stall, flush.
- Valid/ready handshake both sides; one instruction in flight in output register.

---
 rtl/rv32_pkg.sv | 32 +++
 rtl/decode_stage_if.sv | 58 +++++
 rtl/imm_gen.sv | 23 ++
 rtl/decode_stage.sv | 114 +++++++++++
 tb/tb_decode_stage.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32_pkg.sv
// RV32I shared definitions: widths, base opcodes and the ID/EX payload record.
package rv32_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [XLEN-1:0]       pc;
    logic [XLEN-1:0]       rs1Data;
    logic [XLEN-1:0]       rs2Data;
    logic [XLEN-1:0]       imm;
    logic [REG_ADDR_W-1:0] rd;
    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic                  funct7b5;
    logic                  regWrite;
    logic                  isLoad;
  } idex_t;

endpackage

// File: rtl/decode_stage_if.sv
// Fetch / register_file / writeback / ID-EX signals of decode_stage.
// Carries out_illegal only when DECODE_ILLEGAL_TRAP_EN is defined.
interface decode_stage_if;
  import rv32_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [31:0]           in_instr;
  logic [XLEN-1:0]       in_pc;
  logic                  flush;
  logic [REG_ADDR_W-1:0] readRegister1;
  logic [REG_ADDR_W-1:0] readRegister2;
  logic [XLEN-1:0]       readData1;
  logic [XLEN-1:0]       readData2;
  logic                  wb_regWrite;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic [XLEN-1:0]       wb_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [XLEN-1:0]       out_pc;
  logic [XLEN-1:0]       out_rs1_data;
  logic [XLEN-1:0]       out_rs2_data;
  logic [REG_ADDR_W-1:0] out_rd;
  logic [XLEN-1:0]       out_imm;
  logic [6:0]            out_opcode;
  logic [2:0]            out_funct3;
  logic                  out_funct7b5;
  logic                  out_reg_write;
  logic                  out_is_load;
`ifdef DECODE_ILLEGAL_TRAP_EN
  logic                  out_illegal;
`endif

  // Decode stage view
  modport slave (
    input  in_valid, in_instr, in_pc, flush, readData1, readData2,
           wb_regWrite, wb_rd, wb_data, out_ready,
    output in_ready, readRegister1, readRegister2, out_valid, out_pc,
           out_rs1_data, out_rs2_data, out_rd, out_imm, out_opcode,
           out_funct3, out_funct7b5, out_reg_write, out_is_load
`ifdef DECODE_ILLEGAL_TRAP_EN
    , output out_illegal
`endif
  );

  // Surrounding pipeline view (fetch, register_file, writeback, execute)
  modport master (
    output in_valid, in_instr, in_pc, flush, readData1, readData2,
           wb_regWrite, wb_rd, wb_data, out_ready,
    input  in_ready, readRegister1, readRegister2, out_valid, out_pc,
           out_rs1_data, out_rs2_data, out_rd, out_imm, out_opcode,
           out_funct3, out_funct7b5, out_reg_write, out_is_load
`ifdef DECODE_ILLEGAL_TRAP_EN
    , input out_illegal
`endif
  );

endinterface

// File: rtl/imm_gen.sv
// RV32I immediate extraction; every format sign-extends from instr[31].
module imm_gen
  import rv32_pkg::*;
(
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm
);

  always_comb begin
    imm = '0;
    unique case (instr[6:0])
      OP_IMM, OP_LOAD, OP_JALR: imm = {{20{instr[31]}}, instr[31:20]};
      OP_STORE:                 imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      OP_BRANCH:                imm = {{19{instr[31]}}, instr[31], instr[7],
                                       instr[30:25], instr[11:8], 1'b0};
      OP_LUI, OP_AUIPC:         imm = {instr[31:12], 12'b0};
      OP_JAL:                   imm = {{11{instr[31]}}, instr[31], instr[19:12],
                                       instr[20], instr[30:21], 1'b0};
      default:                  imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: register_file read, writeback bypass, load-use stall, ID/EX register.
// Optional DECODE_ILLEGAL_TRAP_EN adds out_illegal for non-base opcodes.
module decode_stage
  import rv32_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  decode_stage_if.slave bus
);

  logic [REG_ADDR_W-1:0] rs1, rs2, rd;
  logic [6:0]            opcode;
  logic [XLEN-1:0]       imm, rs1Data, rs2Data;
  logic                  hazard, inReady, writesRd, outValid;
  idex_t                 idex, idexNext;
`ifdef DECODE_ILLEGAL_TRAP_EN
  logic                  legal, outIllegal;
`endif

  assign opcode = bus.in_instr[6:0];
  assign rd     = bus.in_instr[11:7];
  assign rs1    = bus.in_instr[19:15];
  assign rs2    = bus.in_instr[24:20];

  assign bus.readRegister1 = rs1;
  assign bus.readRegister2 = rs2;

  imm_gen u_immGen (.instr(bus.in_instr), .imm(imm));

  // register_file updates at the same edge we capture, so forward the in-flight write
  always_comb begin
    rs1Data = bus.readData1;
    rs2Data = bus.readData2;
    if (rs1 == '0)                                   rs1Data = '0;
    else if (bus.wb_regWrite && (bus.wb_rd == rs1))  rs1Data = bus.wb_data;
    if (rs2 == '0)                                   rs2Data = '0;
    else if (bus.wb_regWrite && (bus.wb_rd == rs2))  rs2Data = bus.wb_data;
  end

  always_comb begin
    writesRd = 1'b0;
    case (opcode)
      OP_R, OP_IMM, OP_LOAD, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: writesRd = 1'b1;
      default: writesRd = 1'b0;
    endcase
  end

`ifdef DECODE_ILLEGAL_TRAP_EN
  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR,
      OP_LUI, OP_AUIPC, OP_FENCE, OP_SYSTEM: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end
`endif

  always_comb begin
    idexNext          = '0;
    idexNext.pc       = bus.in_pc;
    idexNext.rs1Data  = rs1Data;
    idexNext.rs2Data  = rs2Data;
    idexNext.imm      = imm;
    idexNext.rd       = rd;
    idexNext.opcode   = opcode;
    idexNext.funct3   = bus.in_instr[14:12];
    idexNext.funct7b5 = bus.in_instr[30];
    idexNext.regWrite = writesRd && (rd != '0);
    idexNext.isLoad   = (opcode == OP_LOAD);
  end

  // A held load blocks any consumer of its rd until it has moved on
  assign hazard  = outValid && idex.isLoad && (idex.rd != '0) &&
                   ((idex.rd == rs1) || (idex.rd == rs2));
  assign inReady = rst_n && !bus.flush && !hazard && (!outValid || bus.out_ready);
  assign bus.in_ready = inReady;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      outValid <= 1'b0;
      idex     <= '0;
`ifdef DECODE_ILLEGAL_TRAP_EN
      outIllegal <= 1'b0;
`endif
    end else if (bus.flush) begin
      outValid <= 1'b0;
    end else if (bus.in_valid && inReady) begin
      outValid <= 1'b1;
      idex     <= idexNext;
`ifdef DECODE_ILLEGAL_TRAP_EN
      outIllegal <= !legal;
`endif
    end else if (outValid && bus.out_ready) begin
      outValid <= 1'b0;
    end
  end

  assign bus.out_valid     = outValid;
  assign bus.out_pc        = idex.pc;
  assign bus.out_rs1_data  = idex.rs1Data;
  assign bus.out_rs2_data  = idex.rs2Data;
  assign bus.out_rd        = idex.rd;
  assign bus.out_imm       = idex.imm;
  assign bus.out_opcode    = idex.opcode;
  assign bus.out_funct3    = idex.funct3;
  assign bus.out_funct7b5  = idex.funct7b5;
  assign bus.out_reg_write = idex.regWrite;
  assign bus.out_is_load   = idex.isLoad;
`ifdef DECODE_ILLEGAL_TRAP_EN
  assign bus.out_illegal   = outIllegal;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed sequences, immediate table, random vs model.
module tb_decode_stage;

  logic clk;
  logic rst_n;
  decode_stage_if bus();

  decode_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [31:0] regs [32];
  assign bus.readData1 = regs[bus.readRegister1];
  assign bus.readData2 = regs[bus.readRegister2];

  typedef struct packed {
    logic [31:0] pc, rs1, rs2, imm;
    logic [4:0]  rd;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7b5, rw, ld, ill;
  } rec_t;

  typedef struct packed {
    logic [31:0] instr, imm;
    logic        rw, ld;
  } vec_t;

  rec_t        slot [$];
  bit          modelKnown = 0;
  int          tests = 0;
  int          fails = 0;
  logic        pendWe;
  logic [4:0]  pendRd;
  logic [31:0] pendData;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] operand(logic [4:0] rs);
    if (rs == 5'd0) return 32'd0;
    if (bus.wb_regWrite && bus.wb_rd == rs) return bus.wb_data;
    return regs[rs];
  endfunction

  // Reference decode written straight from the ISA field definitions
  function automatic rec_t decode(logic [31:0] ins, logic [31:0] pc);
    rec_t r;
    logic [6:0] op;
    int imm;
    op = ins[6:0];
    r = '0;
    r.pc = pc; r.op = op; r.rd = ins[11:7]; r.f3 = ins[14:12]; r.f7b5 = ins[30];
    r.rs1 = operand(ins[19:15]);
    r.rs2 = operand(ins[24:20]);
    imm = 0;
    case (op)
      7'h13, 7'h03, 7'h67: imm = int'($signed(ins) >>> 20);
      7'h23: imm = int'($signed(ins) >>> 25) * 32 + int'(ins[11:7]);
      7'h63: imm = (ins[31] ? -4096 : 0) + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
      7'h37, 7'h17: imm = int'(ins & 32'hFFFFF000);
      7'h6F: imm = (ins[31] ? -(1 << 20) : 0) + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
      default: imm = 0;
    endcase
    r.imm = 32'(imm);
    r.rw = (op inside {7'h33, 7'h13, 7'h03, 7'h6F, 7'h67, 7'h37, 7'h17}) && (r.rd != 5'd0);
    r.ld = (op == 7'h03);
    r.ill = !(op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h0F, 7'h73});
    return r;
  endfunction

  task automatic compareRec(rec_t e);
    check("out_pc", bus.out_pc, e.pc);
    check("out_rs1_data", bus.out_rs1_data, e.rs1);
    check("out_rs2_data", bus.out_rs2_data, e.rs2);
    check("out_imm", bus.out_imm, e.imm);
    check("out_rd", 32'(bus.out_rd), 32'(e.rd));
    check("out_opcode", 32'(bus.out_opcode), 32'(e.op));
    check("out_funct3", 32'(bus.out_funct3), 32'(e.f3));
    check("out_funct7b5", 32'(bus.out_funct7b5), 32'(e.f7b5));
    check("out_reg_write", 32'(bus.out_reg_write), 32'(e.rw));
    check("out_is_load", 32'(bus.out_is_load), 32'(e.ld));
`ifdef DECODE_ILLEGAL_TRAP_EN
    check("out_illegal", 32'(bus.out_illegal), 32'(e.ill));
`endif
  endtask

  // One clock: check against the model, advance the model, apply the writeback to regs
  task automatic cycle();
    logic [4:0] rs1, rs2;
    logic hz, expReady;
    rec_t r;
    #1;
    rs1 = bus.in_instr[19:15];
    rs2 = bus.in_instr[24:20];
    hz = (slot.size() != 0) && slot[0].ld && (slot[0].rd != 5'd0) &&
         (slot[0].rd == rs1 || slot[0].rd == rs2);
    expReady = rst_n && !bus.flush && !hz && (slot.size() == 0 || bus.out_ready);
    check("in_ready", 32'(bus.in_ready), 32'(expReady));
    if (modelKnown) begin
      check("out_valid", 32'(bus.out_valid), 32'(slot.size() != 0));
      if (slot.size() != 0) compareRec(slot[0]);
    end
    if (!rst_n) begin
      slot.delete();
      modelKnown = 1;
    end else if (bus.flush) begin
      slot.delete();
    end else if (bus.in_valid && expReady) begin
      r = decode(bus.in_instr, bus.in_pc);
      slot.delete();
      slot.push_back(r);
    end else if (slot.size() != 0 && bus.out_ready) begin
      slot.delete();
    end
    pendWe = bus.wb_regWrite; pendRd = bus.wb_rd; pendData = bus.wb_data;
    @(posedge clk);
    @(negedge clk);
    if (pendWe && pendRd != 5'd0) regs[pendRd] = pendData;
  endtask

  task automatic drive(logic v, logic [31:0] ins, logic [31:0] pc, logic ordy);
    bus.in_valid = v; bus.in_instr = ins; bus.in_pc = pc; bus.out_ready = ordy;
  endtask

  logic [6:0] ops [12] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F,
                          7'h67, 7'h37, 7'h17, 7'h0F, 7'h73, 7'h5B};
  vec_t vecs [$];

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    rst_n = 1'b0;
    bus.flush = 1'b0;
    bus.wb_regWrite = 1'b0; bus.wb_rd = '0; bus.wb_data = '0;
    drive(1'b1, 32'h00208133, 32'h40, 1'b1);

    // Reset with a pending instruction
    #1 check("in_ready_rst", 32'(bus.in_ready), 32'd0);
    cycle();
    cycle();
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_pc", bus.out_pc, 32'd0);
    check("rst_out_imm", bus.out_imm, 32'd0);
    check("rst_out_rs1", bus.out_rs1_data, 32'd0);
    check("rst_out_rs2", bus.out_rs2_data, 32'd0);
    check("rst_out_rd_op", {bus.out_rd, bus.out_opcode, bus.out_funct3, bus.out_funct7b5,
                            bus.out_reg_write, bus.out_is_load}, 32'd0);
`ifdef DECODE_ILLEGAL_TRAP_EN
    check("rst_out_illegal", 32'(bus.out_illegal), 32'd0);
`endif
    rst_n = 1'b1;

    // ADDI x5,x1,-3
    regs[1] = 32'h10;
    drive(1'b1, 32'hFFD08293, 32'h100, 1'b1);
    cycle();
    check("addi_valid", 32'(bus.out_valid), 32'd1);
    check("addi_rd", 32'(bus.out_rd), 32'd5);
    check("addi_imm", bus.out_imm, 32'hFFFFFFFD);
    check("addi_rs1", bus.out_rs1_data, 32'h10);
    check("addi_rw", 32'(bus.out_reg_write), 32'd1);

    // Writeback bypass into ADD x3,x1,x2, then rs1=x0 with wb_rd=0
    regs[1] = 32'h0;
    bus.wb_regWrite = 1'b1; bus.wb_rd = 5'd1; bus.wb_data = 32'hCAFEF00D;
    drive(1'b1, 32'h002081B3, 32'h104, 1'b1);
    cycle();
    check("bypass_rs1", bus.out_rs1_data, 32'hCAFEF00D);
    bus.wb_rd = 5'd0; bus.wb_data = 32'h12345678;
    drive(1'b1, 32'h002001B3, 32'h108, 1'b1);
    cycle();
    check("x0_rs1", bus.out_rs1_data, 32'h0);
    bus.wb_regWrite = 1'b0;

    // Load-use: LW x7,0(x2) then ADD x8,x7,x1
    drive(1'b1, 32'h00012383, 32'h10C, 1'b1);
    cycle();
    drive(1'b1, 32'h00138433, 32'h110, 1'b1);
    #1 check("lu_stall", 32'(bus.in_ready), 32'd0);
    cycle();
    check("lu_bubble", 32'(bus.out_valid), 32'd0);
    #1 check("lu_release", 32'(bus.in_ready), 32'd1);
    cycle();
    check("lu_add_valid", 32'(bus.out_valid), 32'd1);
    check("lu_add_rd", 32'(bus.out_rd), 32'd8);

    // Backpressure holds the register, flush then empties it
    drive(1'b1, 32'hFFD08293, 32'h200, 1'b1);
    cycle();
    drive(1'b1, 32'h002081B3, 32'h204, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #1 check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      cycle();
      check("bp_pc_hold", bus.out_pc, 32'h200);
      check("bp_imm_hold", bus.out_imm, 32'hFFFFFFFD);
    end
    bus.flush = 1'b1;
    cycle();
    check("flush_valid", 32'(bus.out_valid), 32'd0);
    bus.flush = 1'b0;

    // Immediate / classification table
    vecs.push_back('{instr: 32'hFE112E23, imm: 32'hFFFFFFFC, rw: 1'b0, ld: 1'b0}); // SW
    vecs.push_back('{instr: 32'hFE000EE3, imm: 32'hFFFFFFFC, rw: 1'b0, ld: 1'b0}); // BEQ
    vecs.push_back('{instr: 32'h123452B7, imm: 32'h12345000, rw: 1'b1, ld: 1'b0}); // LUI
    vecs.push_back('{instr: 32'h80000517, imm: 32'h80000000, rw: 1'b1, ld: 1'b0}); // AUIPC
    vecs.push_back('{instr: 32'hFFDFF0EF, imm: 32'hFFFFFFFC, rw: 1'b1, ld: 1'b0}); // JAL x1,-4
    vecs.push_back('{instr: 32'h80012303, imm: 32'hFFFFF800, rw: 1'b1, ld: 1'b1}); // LW x6,-2048(x2)
    vecs.push_back('{instr: 32'h0FF0000F, imm: 32'h0,        rw: 1'b0, ld: 1'b0}); // FENCE
    vecs.push_back('{instr: 32'hFFFFFFFB, imm: 32'h0,        rw: 1'b0, ld: 1'b0}); // unknown
    vecs.push_back('{instr: 32'h00000013, imm: 32'h0,        rw: 1'b0, ld: 1'b0}); // NOP rd=0
    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].instr, 32'h300 + 32'(i) * 4, 1'b1);
      cycle();
      check("tbl_imm", bus.out_imm, vecs[i].imm);
      check("tbl_rw", 32'(bus.out_reg_write), 32'(vecs[i].rw));
      check("tbl_ld", 32'(bus.out_is_load), 32'(vecs[i].ld));
    end

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      logic [31:0] ins;
      ins = $urandom;
      ins[6:0]   = ops[$urandom_range(0, 11)];
      ins[11:7]  = 5'($urandom_range(0, 3));
      ins[19:15] = 5'($urandom_range(0, 3));
      ins[24:20] = 5'($urandom_range(0, 3));
      drive(($urandom_range(0, 9) < 7), ins, $urandom, ($urandom_range(0, 9) < 7));
      bus.flush = ($urandom_range(0, 19) == 0);
      rst_n = ($urandom_range(0, 63) != 0);
      bus.wb_regWrite = $urandom_range(0, 1) == 1;
      bus.wb_rd = 5'($urandom_range(0, 3));
      bus.wb_data = $urandom;
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
